// File: rtl/csa_resolver_if.sv
// Handshake/data bundle for csa_resolver; the cin signal exists only when
// CSA_RESOLVER_CIN_EN is defined.
interface csa_resolver_if #(
  parameter int N = 16
);
  localparam int W = N + 2;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] s;
  logic [N-1:0] co;
`ifdef CSA_RESOLVER_CIN_EN
  logic         cin;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;

`ifdef CSA_RESOLVER_CIN_EN
  modport master (output in_valid, s, co, cin, out_ready,
                  input  in_ready, out_valid, result);
  modport slave  (input  in_valid, s, co, cin, out_ready,
                  output in_ready, out_valid, result);
`else
  modport master (output in_valid, s, co, out_ready,
                  input  in_ready, out_valid, result);
  modport slave  (input  in_valid, s, co, out_ready,
                  output in_ready, out_valid, result);
`endif
endinterface

// File: rtl/csa_resolver.sv
// Multi-cycle carry-propagate resolver: result = s + 2*co (+ cin when
// CSA_RESOLVER_CIN_EN is defined), CHUNK bits per cycle.
module csa_resolver #(
  parameter int N     = 16,
  parameter int CHUNK = 4
) (
  input  logic                clk,
  input  logic                rst,
  csa_resolver_if.slave       bus,
  output logic [1:0]          o_dbg_state
);
  localparam int W    = N + 2;
  localparam int NCH  = (W + CHUNK - 1) / CHUNK;
  localparam int PW   = NCH * CHUNK;
  localparam int IW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_a;
  logic [PW-1:0]   r_b;
  logic [PW-1:0]   r_res;
  logic            r_carry;
  logic [IW-1:0]   r_idx;

  logic            w_accept;
  logic            w_cin0;
  logic [PW-1:0]   w_a_init;
  logic [PW-1:0]   w_b_init;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]  w_sum;

  // Valid/ready: a transfer happens on a rising edge where valid && ready;
  // the producer holds its data stable until then, the consumer may assert
  // ready independently of valid.
  always_comb begin
    w_state_nxt   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        if (r_idx == LAST_IDX) w_state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  assign w_accept    = (r_state == IDLE) && bus.in_valid;
  assign o_dbg_state = r_state;

`ifdef CSA_RESOLVER_CIN_EN
  assign w_cin0 = bus.cin;
`else
  assign w_cin0 = 1'b0;
`endif

  // co is shifted up one place so both operands share bit weights.
  always_comb begin
    w_a_init         = '0;
    w_b_init         = '0;
    w_a_init[W-1:0]  = {2'b00, bus.s};
    w_b_init[W-1:0]  = {1'b0, bus.co, 1'b0};
  end

  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int c = 0; c < NCH; c++) begin
      if (r_idx == IW'(c)) begin
        w_a_chunk = r_a[c*CHUNK +: CHUNK];
        w_b_chunk = r_b[c*CHUNK +: CHUNK];
      end
    end
  end

  assign w_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= w_a_init;
      r_b     <= w_b_init;
      r_carry <= w_cin0;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      for (int c = 0; c < NCH; c++) begin
        if (r_idx == IW'(c)) r_res[c*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
      end
      r_carry <= w_sum[CHUNK];
      r_idx   <= (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
    end
  end

  assign bus.result = r_res[W-1:0];
endmodule

// File: tb/tb_csa_resolver.sv
// Directed bench for csa_resolver at CHUNK=4, plus CHUNK=1 and CHUNK=18 sweeps.
module tb_csa_resolver;
  localparam int N = 16;
  localparam int W = N + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csa_resolver_if #(.N(N)) bus4 ();
  csa_resolver_if #(.N(N)) bus1 ();
  csa_resolver_if #(.N(N)) bus18 ();
  logic [1:0] st4, st1, st18;

  csa_resolver #(.N(N), .CHUNK(4))  dut   (.clk(clk), .rst(rst), .bus(bus4),  .o_dbg_state(st4));
  csa_resolver #(.N(N), .CHUNK(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1),  .o_dbg_state(st1));
  csa_resolver #(.N(N), .CHUNK(18)) dut18 (.clk(clk), .rst(rst), .bus(bus18), .o_dbg_state(st18));

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [N-1:0] s,
                       input logic [N-1:0] co, input logic c, input logic ordy);
    case (sel)
      1: begin
        bus1.in_valid = v; bus1.s = s; bus1.co = co; bus1.out_ready = ordy;
`ifdef CSA_RESOLVER_CIN_EN
        bus1.cin = c;
`endif
      end
      18: begin
        bus18.in_valid = v; bus18.s = s; bus18.co = co; bus18.out_ready = ordy;
`ifdef CSA_RESOLVER_CIN_EN
        bus18.cin = c;
`endif
      end
      default: begin
        bus4.in_valid = v; bus4.s = s; bus4.co = co; bus4.out_ready = ordy;
`ifdef CSA_RESOLVER_CIN_EN
        bus4.cin = c;
`endif
      end
    endcase
  endtask

  task automatic sample(input int sel, output logic ir, output logic ov, output logic [W-1:0] res);
    case (sel)
      1:       begin ir = bus1.in_ready;  ov = bus1.out_valid;  res = bus1.result;  end
      18:      begin ir = bus18.in_ready; ov = bus18.out_valid; res = bus18.result; end
      default: begin ir = bus4.in_ready;  ov = bus4.out_valid;  res = bus4.result;  end
    endcase
  endtask

  function automatic logic [W-1:0] model(input logic [N-1:0] s, input logic [N-1:0] co, input logic c);
    logic [W-1:0] r;
    r = W'(s) + (W'(co) << 1);
`ifdef CSA_RESOLVER_CIN_EN
    r = r + W'(c);
`endif
    return r;
  endfunction

  // Accept one pair, wait for out_valid with a cycle budget, check latency and
  // result, complete the transfer and confirm the return to idle.
  task automatic run_op(input int sel, input logic [N-1:0] s, input logic [N-1:0] co,
                        input logic c, input int nch, input string tag);
    logic ir, ov;
    logic [W-1:0] res;
    int lat;
    @(negedge clk);
    sample(sel, ir, ov, res);
    check({tag, "_in_ready"}, 32'(ir), 32'd1);
    drive(sel, 1'b1, s, co, c, 1'b0);
    exp_q.push_back(model(s, co, c));
    @(posedge clk);
    #1 drive(sel, 1'b0, ~s, ~co, ~c, 1'b0);
    lat = 0;
    ov  = 1'b0;
    while (!ov && lat < 40) begin
      @(posedge clk);
      lat++;
      #1 sample(sel, ir, ov, res);
    end
    check({tag, "_latency"}, 32'(lat), 32'(nch));
    check({tag, "_result"}, 32'(res), 32'(exp_q.pop_front()));
    @(negedge clk);
    drive(sel, 1'b0, ~s, ~co, ~c, 1'b1);
    @(posedge clk);
    #1 sample(sel, ir, ov, res);
    check({tag, "_ov_after_xfer"}, 32'(ov), 32'd0);
    check({tag, "_ir_after_xfer"}, 32'(ir), 32'd1);
    drive(sel, 1'b0, ~s, ~co, ~c, 1'b0);
  endtask

  initial begin
    logic ir, ov;
    logic [W-1:0] res;
    logic [N-1:0] rs, rco;
    logic rc;

    rst = 1'b1;
    drive(4, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(18, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    sample(4, ir, ov, res);
    check("rst_in_ready", 32'(ir), 32'd1);
    check("rst_out_valid", 32'(ov), 32'd0);
    check("rst_result", 32'(res), 32'd0);
    check("rst_state", 32'(st4), 32'd0);
    rst = 1'b0;

    run_op(4, 16'h0003, 16'h0001, 1'b0, 5, "basic");
    run_op(4, 16'hFFFF, 16'hFFFF, 1'b0, 5, "max");
    run_op(4, 16'h8000, 16'h8000, 1'b0, 5, "top_bits");
    run_op(4, 16'h0000, 16'h0000, 1'b0, 5, "zero");

    // Backpressure: result held for 10 cycles, in_valid pulse ignored.
    @(negedge clk);
    drive(4, 1'b1, 16'h00A5, 16'h0102, 1'b0, 1'b0);
    @(posedge clk);
    #1 drive(4, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sample(4, ir, ov, res);
      check("bp_out_valid", 32'(ov), 32'd1);
      check("bp_result", 32'(res), 32'h002A9);
      check("bp_in_ready", 32'(ir), 32'd0);
      drive(4, (i == 4), 16'h5555, 16'h5555, 1'b0, 1'b0);
    end
    @(negedge clk);
    drive(4, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    @(posedge clk);
    #1 sample(4, ir, ov, res);
    check("bp_release_ov", 32'(ov), 32'd0);
    check("bp_release_state", 32'(st4), 32'd0);
    drive(4, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("bp_no_ghost_op", 32'(st4), 32'd0);

    // Reset during RUN at chunk 2.
    @(negedge clk);
    drive(4, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    @(posedge clk);
    #1 drive(4, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrun_state_before", 32'(st4), 32'd1);
    rst = 1'b1;
    #1 sample(4, ir, ov, res);
    check("midrun_rst_ov", 32'(ov), 32'd0);
    check("midrun_rst_ir", 32'(ir), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_op(4, 16'h1234, 16'h0001, 1'b0, 5, "after_rst");

`ifdef CSA_RESOLVER_CIN_EN
    run_op(4, 16'hFFFF, 16'hFFFF, 1'b1, 5, "cin_max");
    run_op(4, 16'h0000, 16'h0000, 1'b1, 5, "cin_zero");
`endif

    for (int i = 0; i < 1000; i++) begin
      rs  = 16'($urandom_range(0, 16'hFFFF));
      rco = 16'($urandom_range(0, 16'hFFFF));
      rc  = 1'($urandom_range(0, 1));
      run_op(1, rs, rco, rc, 18, "sweep_c1");
      run_op(18, rs, rco, rc, 1, "sweep_c18");
      if (i < 50) run_op(4, rs, rco, rc, 5, "sweep_c4");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/csa_resolver.md
# csa_resolver

Sequential carry-propagate resolver for carry-save (redundant) operands produced by the 3:2 compression stages. It accepts one sum/carry vector pair, adds them as `s + (co << 1)` over several cycles, CHUNK bits per cycle with a registered inter-chunk carry, and returns a plain binary result. It sits at the tail of a compression tree, where a full-width single-cycle adder would limit timing. Valid/ready handshakes are used on both sides.

## Interface
Parameters:
- `N`, 16, width of the input `s` and `co` vectors.
- `CHUNK`, 4, bits resolved per cycle. Legal range is 1..N+2.

Ports (`W = N+2`, `NCH = ceil(W/CHUNK)`):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  input pair offered.
- `in_ready`  out  1  block can accept a pair.
- `s`  in  N  sum vector (weight 2^i at bit i).
- `co`  in  N  carry vector (weight 2^(i+1) at bit i).
- `out_valid`  out  1  `result` is valid.
- `out_ready`  in  1  downstream accepts `result`.
- `result`  out  W  `s + 2*co`. Zero-extended; it never overflows, since the maximum is 3*2^N-3.
- `cin`  in  1  carry-in at weight 2^0. Present only with `CSA_RESOLVER_CIN_EN`.

## Operation
- State machine with three states:
  - **IDLE**:
    - `in_ready`=1.
    - On `in_valid`&&`in_ready`, capture operand A = `{2'b0,s}` and operand B = `{1'b0,co,1'b0}`, both zero-padded to NCH*CHUNK bits.
    - Clear the chunk index and the carry register (carry = `cin` when configured).
    - Go to RUN.
  - **RUN**:
    - Each cycle, add chunk `idx` of A, chunk `idx` of B and the carry register.
    - Write the CHUNK-bit sum into chunk `idx` of the result register.
    - Store the carry-out in the carry register and increment `idx`.
    - After the chunk with `idx`==NCH-1 is written, go to DONE.
  - **DONE**:
    - `out_valid`=1 and `result` is held stable.
    - On `out_ready`, go to IDLE.
- `in_ready` is 1 only in IDLE. There is no overlap between operations and no input buffering.
- `in_valid` while busy is ignored. Inputs are sampled only on the accept edge, so they may change freely afterwards.
- `result` is the low W bits of the result register. Padding bits above W always end as 0, and the final carry-out is always 0.
- Reset, including mid-operation: the state returns to IDLE and any in-flight operation is discarded without output.
  - Output reset values: `in_ready`=1, `out_valid`=0, `result`=0.
  - Internal registers A, B, carry and `idx` reset to 0.

## Timing
- Accept edge at cycle k. RUN occupies edges k+1 .. k+NCH. `out_valid` rises after edge k+NCH.
- Latency from accept to `out_valid` is NCH cycles. Defaults (N=16, CHUNK=4, W=18): NCH=5.
- Handshake in DONE:
  - `out_valid`&&`out_ready` at edge j completes the transfer; `in_ready`=1 after edge j.
  - A new accept is possible at edge j+1.
  - Throughput is one result per NCH+2 cycles when `out_ready` is held at 1.
- `out_ready` is ignored outside DONE. `out_valid` never drops without a completed transfer, except on reset.
- `result` may change during RUN. It is only meaningful while `out_valid`=1.

## Configuration
- Macro `CSA_RESOLVER_CIN_EN`.
- **Defined:**
  - Port `cin` exists and is captured on the accept edge as the initial value of the carry register.
  - `result` = `s + 2*co + cin`, with a maximum of 3*2^N-2, which still fits in W bits.
- **Undefined:**
  - No `cin` port, and the carry register initialises to 0.
  - All timing is identical in both configurations.

## Test plan
- Basic add, defaults: `s`=0x0003, `co`=0x0001, accepted at cycle 0 -> `out_valid` after edge 5 with `result`=0x00005.
- Maximum operands: `s`=0xFFFF, `co`=0xFFFF -> `result`=0x2FFFD. This checks that the carry chain propagates across all 5 chunks.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE.
  - `result` stays stable and `out_valid` stays 1.
  - `in_ready` stays 0 and a pulsed `in_valid` is ignored.
  - `out_ready`=1 -> IDLE on the next edge.
- Reset mid-RUN: assert `rst` at chunk 2 -> `out_valid`=0, `in_ready`=1 immediately. A new pair `s`=0x1234, `co`=0x0001 accepted afterwards gives `result`=0x01236.
- Parameter sweep: CHUNK=1 (NCH=18) and CHUNK=18 (NCH=1) over 1000 random pairs -> `result` == `s+2*co`, with latency equal to NCH.
- With `CSA_RESOLVER_CIN_EN`: `s`=0xFFFF, `co`=0xFFFF, `cin`=1 -> `result`=0x2FFFE. Random pairs give `result` == `s+2*co+cin`.
